// File: rtl/carrega_matrizes_if.sv
// Byte-wide memory read port: registered request/address out, data plus valid strobe back.
interface carrega_matrizes_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              mem_valid;

  modport master (output mem_addr, mem_rd, input mem_data, mem_valid);
  modport slave  (input mem_addr, mem_rd, output mem_data, mem_valid);
endinterface

// File: rtl/carrega_matrizes.sv
// Loads 5x5 byte matrices A and B (plus the scalar when CARREGA_ESCALAR_EN is defined) into packed 200-bit buses.
// Latency: 1 request cycle + N>=1 wait cycles per byte; done pulses the cycle after the last capture.
// Backpressure: one outstanding read, waits indefinitely for mem_valid; start is ignored while busy.
module carrega_matrizes #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] addr_escalar,
  carrega_matrizes_if.master mem,
  output logic [199:0]      matriz_a,
  output logic [199:0]      matriz_b,
  output logic [7:0]        data_escalar,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    WAIT_A,
    REQ_B,
    WAIT_B,
`ifdef CARREGA_ESCALAR_EN
    REQ_E,
    WAIT_E,
`endif
    DONE
  } state_t;

  state_t            state, state_next;
  logic [4:0]        k, k_next;
  logic [ADDR_W-1:0] base_a_q, base_b_q;
  logic [ADDR_W-1:0] mem_addr_q, addr_base, rd_addr;
  logic              mem_rd_q, rd_next;
  logic              cap_a, cap_b;
  logic [7:0]        elem_idx;

  assign elem_idx     = {k, 3'b000};
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

`ifdef CARREGA_ESCALAR_EN
  logic [ADDR_W-1:0] addr_e_q;
  logic              cap_e;
`else
  wire unused_addr_escalar = ^addr_escalar;
  assign data_escalar = 8'h00;
`endif

  always_comb begin
    state_next = state;
    k_next     = k;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
`ifdef CARREGA_ESCALAR_EN
    cap_e      = 1'b0;
`endif
    case (state)
      IDLE: if (start) begin
        state_next = REQ_A;
        k_next     = '0;
      end
      REQ_A: state_next = WAIT_A;
      WAIT_A: if (mem.mem_valid) begin
        cap_a = 1'b1;
        if (k == 5'd24) begin
          k_next     = '0;
          state_next = REQ_B;
        end else begin
          k_next     = k + 5'd1;
          state_next = REQ_A;
        end
      end
      REQ_B: state_next = WAIT_B;
      WAIT_B: if (mem.mem_valid) begin
        cap_b = 1'b1;
        if (k == 5'd24) begin
          k_next = '0;
`ifdef CARREGA_ESCALAR_EN
          state_next = REQ_E;
`else
          state_next = DONE;
`endif
        end else begin
          k_next     = k + 5'd1;
          state_next = REQ_B;
        end
      end
`ifdef CARREGA_ESCALAR_EN
      REQ_E: state_next = WAIT_E;
      WAIT_E: if (mem.mem_valid) begin
        cap_e      = 1'b1;
        state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request and address are registered from the next state so they line up with the REQ cycle.
  // On the start edge the bases are not latched yet, so REQ_A takes base_a straight from the port.
  always_comb begin
    rd_next   = 1'b0;
    addr_base = base_a_q;
    case (state_next)
      REQ_A: begin
        rd_next   = 1'b1;
        addr_base = (state == IDLE) ? base_a : base_a_q;
      end
      REQ_B: begin
        rd_next   = 1'b1;
        addr_base = base_b_q;
      end
`ifdef CARREGA_ESCALAR_EN
      REQ_E: begin
        rd_next   = 1'b1;
        addr_base = addr_e_q;
      end
`endif
      default: ;
    endcase
  end

  assign rd_addr = addr_base + ADDR_W'(k_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      matriz_a   <= '0;
      matriz_b   <= '0;
    end else begin
      state    <= state_next;
      k        <= k_next;
      mem_rd_q <= rd_next;
      if (rd_next) mem_addr_q <= rd_addr;
      if (state == IDLE && start) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
      end
      if (cap_a) matriz_a[elem_idx +: 8] <= mem.mem_data;
      if (cap_b) matriz_b[elem_idx +: 8] <= mem.mem_data;
    end
  end

`ifdef CARREGA_ESCALAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_e_q     <= '0;
      data_escalar <= '0;
    end else begin
      if (state == IDLE && start) addr_e_q <= addr_escalar;
      if (cap_e) data_escalar <= mem.mem_data;
    end
  end
`endif

endmodule

// File: tb/tb_carrega_matrizes.sv
// Directed bench for carrega_matrizes: reset, table of full loads, mid-load reset.
module tb_carrega_matrizes;
  localparam int AW = 9;

`ifdef CARREGA_ESCALAR_EN
  localparam int         NRD     = 51;
  localparam int         DONE_ZW = 102;
  localparam int         DONE_VW = 204;
  localparam logic [7:0] EXP_ESC = 8'h80;
`else
  localparam int         NRD     = 50;
  localparam int         DONE_ZW = 100;
  localparam int         DONE_VW = 200;
  localparam logic [7:0] EXP_ESC = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] base_a, base_b, addr_escalar;
  logic [199:0]  matriz_a, matriz_b;
  logic [7:0]    data_escalar;
  logic          busy, done;

  carrega_matrizes_if #(.ADDR_W(AW)) mem_if ();

  carrega_matrizes #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_a       (base_a),
    .base_b       (base_b),
    .addr_escalar (addr_escalar),
    .mem          (mem_if),
    .matriz_a     (matriz_a),
    .matriz_b     (matriz_b),
    .data_escalar (data_escalar),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: byte i holds i[7:0]; valid rises dly cycles after a request and lasts hold cycles.
  logic [7:0]    memory [512];
  logic [AW-1:0] rd_addrs [1024];
  logic [AW-1:0] paddr = '0;
  int dly = 1, hold = 1, pend = 0, vcnt = 0, rd_cnt = 0;

  initial begin
    for (int i = 0; i < 512; i++) memory[i] = i[7:0];
    mem_if.mem_valid = 1'b0;
    mem_if.mem_data  = 8'h00;
  end

  always begin
    @(posedge clk);
    #1;
    if (vcnt > 0) vcnt--;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        vcnt = hold;
        mem_if.mem_data = memory[paddr];
      end
    end
    mem_if.mem_valid = (vcnt > 0);
    if (mem_if.mem_rd === 1'b1) begin
      pend  = dly;
      paddr = mem_if.mem_addr;
      if (rd_cnt < 1024) rd_addrs[rd_cnt] = mem_if.mem_addr;
      rd_cnt++;
    end
  end

  function automatic logic [199:0] exp_mat(input logic [AW-1:0] base);
    logic [199:0]  m;
    logic [AW-1:0] a;
    m = '0;
    for (int k = 0; k < 25; k++) begin
      a = base + AW'(k);
      m[k*8 +: 8] = memory[a];
    end
    return m;
  endfunction

  typedef struct {
    logic [AW-1:0] ba, bb, be;
    int            dly, hold;
    bit            busy_start;
    logic [7:0]    a0, a24, b24;
    logic [AW-1:0] addr24;
    int            done_j;
  } vec_t;

  vec_t vecs [3];

  function automatic logic [AW-1:0] rd_at(input int idx);
    if (idx < 1024 && idx < rd_cnt) return rd_addrs[idx];
    return 'x;
  endfunction

  task automatic run_load(input vec_t v, input string tag);
    int j;
    int rd0;
    base_a = v.ba; base_b = v.bb; addr_escalar = v.be;
    dly = v.dly; hold = v.hold;
    rd0 = rd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    check({tag, "_busy_after_start"}, 200'(busy), 200'(1));
    while (!done && j < 600) begin
      if (v.busy_start && j == 20) begin
        start = 1'b1;
        base_a = 9'h100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 200'(j), 200'(v.done_j));
    check({tag, "_busy_in_done"}, 200'(busy), 200'(1));
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 200'({done, busy}), 200'(0));
    check({tag, "_matriz_a"}, matriz_a, exp_mat(v.ba));
    check({tag, "_matriz_b"}, matriz_b, exp_mat(v.bb));
    check({tag, "_a0"}, 200'(matriz_a[7:0]), 200'(v.a0));
    check({tag, "_a24"}, 200'(matriz_a[199:192]), 200'(v.a24));
    check({tag, "_b24"}, 200'(matriz_b[199:192]), 200'(v.b24));
    check({tag, "_escalar"}, 200'(data_escalar), 200'(EXP_ESC));
    check({tag, "_addr_a0"}, 200'(rd_at(rd0)), 200'(v.ba));
    check({tag, "_addr_a24"}, 200'(rd_at(rd0 + 24)), 200'(v.addr24));
    check({tag, "_addr_b0"}, 200'(rd_at(rd0 + 25)), 200'(v.bb));
    repeat (3) @(negedge clk);
    check({tag, "_read_count"}, 200'(rd_cnt - rd0), 200'(NRD));
  endtask

  initial begin
    int rd0;
    int j;
    vecs[0] = '{ba: 9'h000, bb: 9'h040, be: 9'h080, dly: 1, hold: 1, busy_start: 1'b0,
                a0: 8'h00, a24: 8'h18, b24: 8'h58, addr24: 9'h018, done_j: DONE_ZW};
    vecs[1] = '{ba: 9'h000, bb: 9'h040, be: 9'h080, dly: 3, hold: 2, busy_start: 1'b0,
                a0: 8'h00, a24: 8'h18, b24: 8'h58, addr24: 9'h018, done_j: DONE_VW};
    vecs[2] = '{ba: 9'h1F0, bb: 9'h040, be: 9'h080, dly: 1, hold: 1, busy_start: 1'b1,
                a0: 8'hF0, a24: 8'h08, b24: 8'h58, addr24: 9'h008, done_j: DONE_ZW};

    rst = 1'b1; start = 1'b0;
    base_a = '0; base_b = '0; addr_escalar = '0;
    repeat (2) @(negedge clk);
    check("rst_matriz_a", matriz_a, 200'(0));
    check("rst_matriz_b", matriz_b, 200'(0));
    check("rst_escalar", 200'(data_escalar), 200'(0));
    check("rst_busy_done", 200'({busy, done}), 200'(0));
    check("rst_mem_rd", 200'(mem_if.mem_rd), 200'(0));
    check("rst_mem_addr", 200'(mem_if.mem_addr), 200'(0));
    rst = 1'b0;
    rd0 = rd_cnt;
    repeat (20) @(negedge clk);
    check("idle_no_reads", 200'(rd_cnt - rd0), 200'(0));

    for (int i = 0; i < 3; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Reset while B element 10 is outstanding; its delayed strobe lands after reset.
    base_a = 9'h000; base_b = 9'h040; addr_escalar = 9'h080;
    dly = 3; hold = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (!(mem_if.mem_rd === 1'b1 && mem_if.mem_addr == 9'h04A) && j < 300) begin
      @(negedge clk);
      j++;
    end
    check("mid_b10_reached", 200'(j < 300), 200'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_matriz_a", matriz_a, 200'(0));
    check("mid_rst_matriz_b", matriz_b, 200'(0));
    check("mid_rst_ctrl", 200'({busy, done, mem_if.mem_rd}), 200'(0));
    check("mid_rst_addr", 200'(mem_if.mem_addr), 200'(0));
    rd0 = rd_cnt;
    repeat (6) @(negedge clk);
    check("late_valid_matriz_b", matriz_b, 200'(0));
    check("late_valid_idle", 200'(busy), 200'(0));
    check("late_valid_no_reads", 200'(rd_cnt - rd0), 200'(0));
    run_load(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/carrega_matrizes.md
# carrega_matrizes

Memory-side loader sitting directly upstream of the matrix arithmetic stages (scalar product, sum, subtraction). On a `start` pulse it reads operand A (25 bytes), operand B (25 bytes) and, optionally, the scalar from a byte-wide memory via a request/valid handshake. It assembles them into the packed 200-bit buses those stages consume, then pulses `done`.

## Interface
- `ADDR_W`, 9: memory byte-address width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load command; sampled only in IDLE.
- `base_a`  in  ADDR_W  byte address of element 0 of matrix A.
- `base_b`  in  ADDR_W  byte address of element 0 of matrix B.
- `addr_escalar`  in  ADDR_W  byte address of the scalar.
- `mem_addr`  out  ADDR_W  read address; registered.
- `mem_rd`  out  1  read request; registered, one-cycle pulse.
- `mem_data`  in  8  read data; valid when `mem_valid` is high.
- `mem_valid`  in  1  read-data strobe from memory.
- `matriz_a`  out  200  element k at `[k*8 +: 8]`.
- `matriz_b`  out  200  same packing as `matriz_a`.
- `data_escalar`  out  8  loaded scalar.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the load completes.

## Operation
- Matrix layout: 5x5, row-major. Element k (0..24) is row k/5, column k%5. It is read from `base + k`. The address wraps modulo 2^ADDR_W, so base 0x1F0 with k=24 gives 0x008.
- Base addresses are latched at `start`. Later changes to them have no effect during the run.
- FSM states and transitions:
  - IDLE: go to REQ_A on `start`.
  - REQ_A: go to WAIT_A.
  - WAIT_A: on `mem_valid`, if k<24 go to REQ_A; otherwise go to REQ_B.
  - REQ_B: go to WAIT_B.
  - WAIT_B: on `mem_valid`, if k<24 go to REQ_B; otherwise go to REQ_E (or to DONE when the macro is absent).
  - REQ_E: go to WAIT_E.
  - WAIT_E: on `mem_valid`, go to DONE.
  - DONE: go to IDLE.
- REQ states: drive `mem_rd`=1 and `mem_addr` for one cycle only.
- WAIT states:
  - `mem_rd`=0.
  - On `mem_valid`=1, `mem_data` is written into the current element and k increments. k resets to 0 at each phase change.
- `mem_valid` is ignored in IDLE, REQ and DONE states. A strobe coincident with `mem_rd` is not accepted.
- Outputs are written element-by-element while the load runs. Downstream treats them as stable only from `done` until the next `start`. Unwritten elements keep their previous value.
- `start` while `busy` is ignored.
- Reset, including mid-load:
  - State goes to IDLE and k to 0.
  - `mem_rd`, `busy`, `done` = 0; `mem_addr` = 0.
  - `matriz_a`, `matriz_b`, `data_escalar` = 0.
  - Any later `mem_valid` belonging to an aborted read is ignored.

## Timing
- `start` is sampled high at edge T. REQ_A is entered at T, so `mem_rd` is high during cycle T+1 with `mem_addr`=`base_a`.
- Each read takes 1 REQ cycle plus N≥1 WAIT cycles. With zero-wait memory (`mem_valid` one cycle after `mem_rd`), each element costs 2 cycles.
- Zero-wait totals:
  - 51 reads: last capture at edge T+102, DONE state in cycle T+103 (`done`=1, `busy`=1), IDLE at T+104.
  - Without the macro: 50 reads, `done` in cycle T+101.
- A new `start` is accepted in the first IDLE cycle after DONE.
- No timeout: a missing `mem_valid` leaves the FSM waiting until reset.

## Configuration
- `CARREGA_ESCALAR_EN`:
  - Defined: the REQ_E/WAIT_E phase exists and `data_escalar` is loaded from `addr_escalar`.
  - Undefined: those states are not compiled, WAIT_B goes directly to DONE, `addr_escalar` is unused, and `data_escalar` is constant 8'h00.

## Test plan
- Reset then idle: assert `rst` 2 cycles -> all outputs 0; `mem_rd` stays 0 for 20 cycles with `start`=0.
- Zero-wait full load, macro on: memory[i]=i. Use `base_a`=0, `base_b`=0x40, `addr_escalar`=0x80. Expect:
  - `matriz_a[7:0]`=0x00 and `matriz_a[199:192]`=0x18.
  - `matriz_b[199:192]`=0x58.
  - `data_escalar`=0x80.
  - `done` exactly 103 cycles after the `start` edge.
  - 51 `mem_rd` pulses.
- Variable wait: `mem_valid` 3 cycles after each `mem_rd` -> identical data; `done` at T+205; a `mem_valid` held extra cycles is not double-captured.
- Address wrap: `base_a`=0x1F0 -> element 24 read from 0x008.
- Mid-load reset: `rst` at element 10 of B -> all outputs 0 next cycle; a late `mem_valid` is ignored; a new `start` loads correctly.
- Macro off: same stimulus as the zero-wait load -> 50 reads, `done` at T+101, `data_escalar`=0x00; `start` during `busy` is ignored.
